// File: rtl/ibex_efpga_responder.sv
// Fabric-side responder for the core<->eFPGA custom-instruction link.
// Captures a request on write_strobe_i, launches the user fabric, and returns
// either the fabric result or ERR_PATTERN after TIMEOUT_CYCLES.
// Optional feature macro: EFPGA_RESP_SHADOW_EN (one-entry request shadow).
module ibex_efpga_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_PATTERN    = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_strobe_i,
    input  logic [1:0]  operator_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    output logic        fab_start_o,
    output logic [1:0]  fab_op_o,
    output logic [31:0] fab_a_o,
    output logic [31:0] fab_b_o,
    input  logic        fab_valid_i,
    input  logic [31:0] fab_res_a_i,
    input  logic [31:0] fab_res_b_i,
    input  logic [31:0] fab_res_c_i,
    output logic [31:0] result_a_o,
    output logic [31:0] result_b_o,
    output logic [31:0] result_c_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic        overrun_o
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 32;
    // WAIT lasts TIMEOUT_CYCLES-1 cycles: the check uses the incremented count
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                start_q, start_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   res_a_q, res_a_d, res_b_q, res_b_d, res_c_q, res_c_d;
    logic                done_q, done_d, busy_q, busy_d;
    logic                timeout_q, timeout_d, overrun_q, overrun_d;

`ifdef EFPGA_RESP_SHADOW_EN
    logic                sh_valid_q, sh_valid_d;
    logic [OP_W-1:0]     sh_op_q, sh_op_d;
    logic [DATA_W-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_a_q   <= '0;
            res_b_q   <= '0;
            res_c_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef EFPGA_RESP_SHADOW_EN
            sh_valid_q <= 1'b0;
            sh_op_q    <= '0;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_a_q   <= res_a_d;
            res_b_q   <= res_b_d;
            res_c_q   <= res_c_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
`ifdef EFPGA_RESP_SHADOW_EN
            sh_valid_q <= sh_valid_d;
            sh_op_q    <= sh_op_d;
            sh_a_q     <= sh_a_d;
            sh_b_q     <= sh_b_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        res_c_d   = res_c_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
`ifdef EFPGA_RESP_SHADOW_EN
        sh_valid_d = sh_valid_q;
        sh_op_d    = sh_op_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
`endif

        // A strobe while busy is parked in the shadow if possible, else lost
        if ((state_q == S_LAUNCH || state_q == S_WAIT) && write_strobe_i) begin
`ifdef EFPGA_RESP_SHADOW_EN
            if (!sh_valid_q) begin
                sh_valid_d = 1'b1;
                sh_op_d    = operator_i;
                sh_a_d     = operand_a_i;
                sh_b_d     = operand_b_i;
            end else begin
                overrun_d = 1'b1;
            end
`else
            overrun_d = 1'b1;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (write_strobe_i) begin
                    op_d      = operator_i;
                    a_d       = operand_a_i;
                    b_d       = operand_b_i;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d     = '0;
                // Drops the done pulse of a previous op after a shadow relaunch
                done_d    = 1'b0;
                timeout_d = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (fab_valid_i) begin
                    res_a_d   = fab_res_a_i;
                    res_b_d   = fab_res_b_i;
                    res_c_d   = fab_res_c_i;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_inc == CNT_LAST) begin
                    res_a_d   = ERR_PATTERN;
                    res_b_d   = '0;
                    res_c_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef EFPGA_RESP_SHADOW_EN
                if (sh_valid_q) begin
                    op_d       = sh_op_q;
                    a_d        = sh_a_q;
                    b_d        = sh_b_q;
                    sh_valid_d = 1'b0;
                    state_d    = S_LAUNCH;
                    if (write_strobe_i) begin
                        sh_valid_d = 1'b1;
                        sh_op_d    = operator_i;
                        sh_a_d     = operand_a_i;
                        sh_b_d     = operand_b_i;
                    end
                end else
`endif
                if (write_strobe_i) begin
                    op_d      = operator_i;
                    a_d       = operand_a_i;
                    b_d       = operand_b_i;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        start_d = (state_d == S_LAUNCH);
        busy_d  = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    end

    assign fab_start_o = start_q;
    assign fab_op_o    = op_q;
    assign fab_a_o     = a_q;
    assign fab_b_o     = b_q;
    assign result_a_o  = res_a_q;
    assign result_b_o  = res_b_q;
    assign result_c_o  = res_c_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_ibex_efpga_responder.sv
// Scoreboard bench for ibex_efpga_responder; follows EFPGA_RESP_SHADOW_EN.
module tb_ibex_efpga_responder;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        write_strobe_i = 1'b0;
    logic [1:0]  operator_i = '0;
    logic [31:0] operand_a_i = '0, operand_b_i = '0;
    logic        fab_start_o;
    logic [1:0]  fab_op_o;
    logic [31:0] fab_a_o, fab_b_o;
    logic        fab_valid_i = 1'b0;
    logic [31:0] fab_res_a_i = '0, fab_res_b_i = '0, fab_res_c_i = '0;
    logic [31:0] result_a_o, result_b_o, result_c_o;
    logic        done_o, busy_o, timeout_o, overrun_o;

    ibex_efpga_responder #(.TIMEOUT_CYCLES(TO), .ERR_PATTERN(ERR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .write_strobe_i(write_strobe_i),
        .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .fab_start_o(fab_start_o), .fab_op_o(fab_op_o), .fab_a_o(fab_a_o), .fab_b_o(fab_b_o),
        .fab_valid_i(fab_valid_i), .fab_res_a_i(fab_res_a_i), .fab_res_b_i(fab_res_b_i),
        .fab_res_c_i(fab_res_c_i), .result_a_o(result_a_o), .result_b_o(result_b_o),
        .result_c_o(result_c_o), .done_o(done_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef EFPGA_RESP_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; } launch_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] c; logic to; int cyc; } exp_t;

    launch_t lq[$];
    exp_t    eq[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int done_seen = 0;
    int n_issued = 0;
    int forced_k = 0;
    bit fab_enable = 1'b1;
    bit fix_en = 1'b0;
    logic [31:0] fix_a = '0, fix_b = '0, fix_c = '0;
    int late_req = 0, late_ack = 0;
    bit exp_overrun = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Fabric model: checks each launch and answers after a chosen delay
    initial begin
        launch_t l;
        exp_t    e;
        int      k, s;
        forever begin
            @(posedge clk_i); #1;
            fab_valid_i = 1'b0;
            if (late_req != late_ack) begin
                late_ack    = late_req;
                fab_valid_i = 1'b1;
                fab_res_a_i = $urandom;
                fab_res_b_i = $urandom;
                fab_res_c_i = $urandom;
            end else if (fab_enable && fab_start_o) begin
                s = cyc;
                if (lq.size() == 0) begin
                    chk("launch_queue_depth", 32'(lq.size()), 32'd1);
                end else begin
                    l = lq.pop_front();
                    chk("fab_op", 32'(fab_op_o), 32'(l.op));
                    chk("fab_a", fab_a_o, l.a);
                    chk("fab_b", fab_b_o, l.b);
                end
                k = (forced_k != 0) ? forced_k : int'($urandom_range(1, TO + 1));
                if (fix_en) begin
                    e.a = fix_a; e.b = fix_b; e.c = fix_c;
                end else begin
                    e.a = $urandom; e.b = $urandom; e.c = $urandom;
                end
                fab_res_a_i = e.a; fab_res_b_i = e.b; fab_res_c_i = e.c;
                if (k <= int'(TO) - 1) begin
                    e.to  = 1'b0;
                    e.cyc = s + k + 2;
                end else begin
                    e.a = ERR; e.b = '0; e.c = '0;
                    e.to  = 1'b1;
                    e.cyc = s + int'(TO) + 1;
                end
                eq.push_back(e);
                // k==TO lands in the completion cycle and must be ignored
                if (k <= int'(TO)) begin
                    repeat (k) @(posedge clk_i);
                    #1;
                    fab_valid_i = 1'b1;
                end
            end
        end
    end

    // Monitor: every rising done_o retires one expected response
    initial begin
        exp_t e;
        logic done_prev = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (done_o && !done_prev) begin
                done_seen++;
                if (eq.size() == 0) begin
                    chk("result_queue_depth", 32'(eq.size()), 32'd1);
                end else begin
                    e = eq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("result_a", result_a_o, e.a);
                    chk("result_b", result_b_o, e.b);
                    chk("result_c", result_c_o, e.c);
                    chk("timeout", 32'(timeout_o), 32'(e.to));
                end
            end
            done_prev = done_o;
        end
    end

    task automatic strobe(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit accept);
        launch_t l;
        write_strobe_i = 1'b1;
        operator_i = op; operand_a_i = a; operand_b_i = b;
        if (accept) begin
            l.op = op; l.a = a; l.b = b;
            lq.push_back(l);
            n_issued++;
        end
        @(negedge clk_i);
        write_strobe_i = 1'b0;
        operand_a_i = $urandom; operand_b_i = $urandom;
    endtask

    task automatic wait_dones(input int target);
        for (int i = 0; i < 200 && done_seen < target; i++) @(negedge clk_i);
        chk("done_count", 32'(done_seen), 32'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_fab_start"}, 32'(fab_start_o), 32'd0);
        chk({tag, "_fab_op"}, 32'(fab_op_o), 32'd0);
        chk({tag, "_fab_a"}, fab_a_o, 32'd0);
        chk({tag, "_fab_b"}, fab_b_o, 32'd0);
        chk({tag, "_res_a"}, result_a_o, 32'd0);
        chk({tag, "_res_b"}, result_b_o, 32'd0);
        chk({tag, "_res_c"}, result_c_o, 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // Reset for three cycles
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed: op=2 A=5 B=7, fabric answers 3 cycles after launch
        forced_k = 3; fix_en = 1'b1; fix_a = 32'd12; fix_b = 32'd0; fix_c = 32'd1;
        strobe(2'd2, 32'd5, 32'd7, 1'b1);
        chk("busy_in_launch", 32'(busy_o), 32'd1);
        wait_dones(n_issued);
        fix_en = 1'b0;

        // Directed: fabric never answers
        forced_k = 200;
        strobe(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_dones(n_issued);
        chk("busy_after_timeout", 32'(busy_o), 32'd0);

        // Random single operations, including the timeout boundary
        forced_k = 0;
        for (int i = 0; i < 24; i++) begin
            strobe(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
            wait_dones(n_issued);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        chk("overrun_clean", 32'(overrun_o), 32'd0);

        // Second strobe while waiting
        forced_k = 6;
        strobe(2'd3, 32'hA, 32'hB, 1'b1);
        @(negedge clk_i);
        strobe(2'd1, 32'hC, 32'hD, SHADOW);
        if (!SHADOW) exp_overrun = 1'b1;
        wait_dones(n_issued);
        repeat (30) @(negedge clk_i);
        chk("second_strobe_dones", 32'(done_seen), 32'(n_issued));
        chk("second_strobe_overrun", 32'(overrun_o), 32'(exp_overrun));

        // Third strobe while shadow (if any) is occupied
        strobe(2'd0, 32'h11, 32'h22, 1'b1);
        @(negedge clk_i);
        strobe(2'd2, 32'h33, 32'h44, SHADOW);
        strobe(2'd3, 32'h55, 32'h66, 1'b0);
        exp_overrun = 1'b1;
        wait_dones(n_issued);
        repeat (30) @(negedge clk_i);
        chk("third_strobe_dones", 32'(done_seen), 32'(n_issued));
        chk("third_strobe_overrun", 32'(overrun_o), 32'(exp_overrun));

        // Reset two cycles into WAIT, then a stray fabric valid
        fab_enable = 1'b0;
        strobe(2'd1, 32'h77, 32'h88, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_busy", 32'(busy_o), 32'd0);
        check_idle_outputs("abort");
        rst_i = 1'b0;
        late_req++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("abort_done_low", 32'(done_o), 32'd0);
            chk("abort_no_start", 32'(fab_start_o), 32'd0);
        end
        fab_enable = 1'b1;

        chk("final_launch_queue", 32'(lq.size()), 32'd0);
        chk("final_result_queue", 32'(eq.size()), 32'd0);
        chk("final_done_total", 32'(done_seen), 32'(n_issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
